// File: rtl/act7_tdm_demux.sv
// rtl/act7_tdm_demux.sv - ACT7 time-division demultiplexer with frame-sync tracking
//
// Receives one sample per enabled cycle on a shared lane and steers each sample
// into a per-slot shadow register. Slot 0 is marked by SYNC. When the last slot
// arrives, the complete frame is published on Y with a one-cycle VALID pulse.
//
// Ports:
//   CLK    in  1             rising-edge clock
//   RST_N  in  1             asynchronous active-low reset
//   EN     in  1             sample strobe; SYNC/D ignored while low
//   SYNC   in  1             current sample is slot 0 of a frame
//   D      in  WIDTH         sample data
//   Y      out SLOTS*WIDTH   last complete frame, slot k at Y[k*WIDTH +: WIDTH]
//   VALID  out 1             one-cycle pulse when Y is updated
//   SLOT   out clog2(SLOTS)  slot index the next accepted sample will occupy
//   ERR    out 1             frame alignment error
//
// Build option ACT7_TDM_STICKY_ERR_EN: when defined, ERR latches on the first
// error and clears only on reset; otherwise ERR pulses once per error event.

module act7_tdm_demux #(
  parameter int WIDTH = 8,
  parameter int SLOTS = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       EN,
  input  logic                       SYNC,
  input  logic [WIDTH-1:0]           D,
  output logic [SLOTS*WIDTH-1:0]     Y,
  output logic                       VALID,
  output logic [$clog2(SLOTS)-1:0]   SLOT,
  output logic                       ERR
);

  localparam int SW = $clog2(SLOTS);
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                   state_q, state_d;
  logic [SW-1:0]            slot_q, slot_d;
  logic [WIDTH-1:0]         shadow_q [SLOTS-1];
  logic [WIDTH-1:0]         shadow_d [SLOTS-1];
  logic [SLOTS*WIDTH-1:0]   y_q, y_d;
  logic                     valid_q, valid_d;
  logic                     err_q, err_d;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= HUNT;
      slot_q  <= '0;
      for (int k = 0; k < SLOTS - 1; k++) shadow_q[k] <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      for (int k = 0; k < SLOTS - 1; k++) shadow_q[k] <= shadow_d[k];
      y_q     <= y_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state: FSM and slot counter
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (EN) begin
      if (state_q == HUNT) begin
        if (SYNC) begin
          state_d = LOCKED;
          slot_d  = SW'(1);
        end
      end else begin
        if (SYNC) begin
          // Either an expected sync at slot 0 or an early sync restarting the frame.
          slot_d = SW'(1);
        end else if (slot_q == '0) begin
          // Slot 0 without a sync marker: alignment lost.
          state_d = HUNT;
          slot_d  = '0;
        end else if (slot_q == LAST_SLOT) begin
          slot_d = '0;
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
    end
  end

  // Outputs: shadow capture, frame publish, strobes
  always_comb begin
    shadow_d = shadow_q;
    y_d      = y_q;
    valid_d  = 1'b0;
`ifdef ACT7_TDM_STICKY_ERR_EN
    err_d    = err_q;
`else
    err_d    = 1'b0;
`endif
    if (EN) begin
      if (SYNC) begin
        // A sync sample always starts a new frame; a partial one is dropped.
        shadow_d[0] = D;
        if (state_q == LOCKED && slot_q != '0) err_d = 1'b1;
      end else if (state_q == LOCKED) begin
        if (slot_q == '0) begin
          err_d = 1'b1;
        end else if (slot_q == LAST_SLOT) begin
          for (int k = 0; k < SLOTS - 1; k++) y_d[k*WIDTH +: WIDTH] = shadow_q[k];
          y_d[(SLOTS-1)*WIDTH +: WIDTH] = D;
          valid_d = 1'b1;
        end else begin
          for (int k = 1; k < SLOTS - 1; k++) begin
            if (slot_q == SW'(k)) shadow_d[k] = D;
          end
        end
      end
    end
  end

  assign Y     = y_q;
  assign VALID = valid_q;
  assign SLOT  = slot_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_act7_tdm_demux.sv
// tb/tb_act7_tdm_demux.sv - directed self-checking bench for act7_tdm_demux

module tb_act7_tdm_demux;

`ifdef ACT7_TDM_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        sync;
  logic [7:0]  d;
  logic [31:0] y;
  logic        valid;
  logic [1:0]  slot;
  logic        err;

  int checks;
  int errors;

  act7_tdm_demux #(.WIDTH(8), .SLOTS(4)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .EN    (en),
    .SYNC  (sync),
    .D     (d),
    .Y     (y),
    .VALID (valid),
    .SLOT  (slot),
    .ERR   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] ey, input logic ev,
                           input logic [1:0] es, input logic ee);
    check({tag, ".Y"},     {32'h0, y},     {32'h0, ey});
    check({tag, ".VALID"}, {63'h0, valid}, {63'h0, ev});
    check({tag, ".SLOT"},  {62'h0, slot},  {62'h0, es});
    check({tag, ".ERR"},   {63'h0, err},   {63'h0, ee});
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic e, input logic s, input logic [7:0] v);
    en   = e;
    sync = s;
    d    = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    sync  = 1'b0;
    d     = 8'h00;

    // Reset held with random traffic
    for (int i = 0; i < 4; i++) step(1'($urandom), 1'($urandom), 8'($urandom));
    check_out("reset", 32'h0, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;

    // Normal frame A then back-to-back frame B
    step(1, 1, 8'hA0); check_out("a0", 32'h0, 0, 2'd1, 0);
    step(1, 0, 8'hA1); check_out("a1", 32'h0, 0, 2'd2, 0);
    step(1, 0, 8'hA2); check_out("a2", 32'h0, 0, 2'd3, 0);
    step(1, 0, 8'hA3); check_out("a3", 32'hA3A2A1A0, 1, 2'd0, 0);
    step(1, 1, 8'hB0); check_out("b0", 32'hA3A2A1A0, 0, 2'd1, 0);
    step(1, 0, 8'hB1); check_out("b1", 32'hA3A2A1A0, 0, 2'd2, 0);
    step(1, 0, 8'hB2); check_out("b2", 32'hA3A2A1A0, 0, 2'd3, 0);
    step(1, 0, 8'hB3); check_out("b3", 32'hB3B2B1B0, 1, 2'd0, 0);

    // Gapped EN: gap cycles drive SYNC=1 and junk data that must be ignored
    for (int i = 0; i < 4; i++) begin
      step(1, (i == 0), 8'hA0 + 8'(i));
      if (i == 3) check_out("gap_last", 32'hA3A2A1A0, 1, 2'd0, 0);
      else        check_out("gap_smp", 32'hB3B2B1B0, 0, 2'(i + 1), 0);
      for (int g = 0; g < 2; g++) begin
        step(0, 1, 8'h5A);
        check_out("gap_hold", (i == 3) ? 32'hA3A2A1A0 : 32'hB3B2B1B0, 0, 2'((i + 1) % 4), 0);
      end
    end

    // Early sync: C frame abandoned, D frame delivered
    step(1, 1, 8'hC0); check_out("c0", 32'hA3A2A1A0, 0, 2'd1, 0);
    step(1, 0, 8'hC1); check_out("c1", 32'hA3A2A1A0, 0, 2'd2, 0);
    step(1, 1, 8'hD0); check_out("d0_early", 32'hA3A2A1A0, 0, 2'd1, 1);
    step(1, 0, 8'hD1); check_out("d1", 32'hA3A2A1A0, 0, 2'd2, STICKY);
    step(1, 0, 8'hD2); check_out("d2", 32'hA3A2A1A0, 0, 2'd3, STICKY);
    step(1, 0, 8'hD3); check_out("d3", 32'hD3D2D1D0, 1, 2'd0, STICKY);

    // Missing sync: frame E, then unsynced slot-0 sample drops to HUNT
    step(1, 1, 8'hE0);
    step(1, 0, 8'hE1);
    step(1, 0, 8'hE2);
    step(1, 0, 8'hE3); check_out("e3", 32'hE3E2E1E0, 1, 2'd0, STICKY);
    step(1, 0, 8'h55); check_out("miss55", 32'hE3E2E1E0, 0, 2'd0, 1);
    step(1, 0, 8'h66); check_out("hunt66", 32'hE3E2E1E0, 0, 2'd0, STICKY);
    step(1, 0, 8'h77); check_out("hunt77", 32'hE3E2E1E0, 0, 2'd0, STICKY);

    // Reset mid-frame, asserted between edges
    step(1, 1, 8'hF0);
    step(1, 0, 8'hF1); check_out("f1", 32'hE3E2E1E0, 0, 2'd2, STICKY);
    #2 rst_n = 1'b0;
    #1 check_out("async_rst", 32'h0, 0, 2'd0, 0);
    #1 rst_n = 1'b1;
    step(1, 0, 8'hF2); check_out("post_f2", 32'h0, 0, 2'd0, 0);
    step(1, 0, 8'hF3); check_out("post_f3", 32'h0, 0, 2'd0, 0);
    step(1, 0, 8'h11); check_out("post_11", 32'h0, 0, 2'd0, 0);
    step(1, 1, 8'h31); check_out("g0", 32'h0, 0, 2'd1, 0);
    step(1, 0, 8'h32);
    step(1, 0, 8'h33);
    step(1, 0, 8'h34); check_out("g3", 32'h34333231, 1, 2'd0, 0);
    step(0, 0, 8'h00); check_out("g_idle", 32'h34333231, 0, 2'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/act7_tdm_demux.md
# act7_tdm_demux

Time-division demultiplexer: the receive end of the ACT7 select-driven multiplexer path. It accepts one sample per enabled cycle on a single shared data lane, tracks the slot index from a frame-sync marker, and steers each sample into its own per-slot register. A complete frame is published in parallel on `Y` with a one-cycle `VALID` strobe. Frame-alignment errors are flagged on `ERR`.

## Interface
- `WIDTH`, default 8: bits per sample.
- `SLOTS`, default 4: slots per frame; power of two, 2..16.
- `CLK` in 1: clock; all state changes on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `EN` in 1: sample strobe; `D`/`SYNC` are meaningful only when `EN`=1.
- `SYNC` in 1: marks the sample as slot 0 of a frame.
- `D` in `WIDTH`: sample data.
- `Y` out `SLOTS*WIDTH`: last complete frame; slot k at `Y[k*WIDTH +: WIDTH]`.
- `VALID` out 1: one-cycle pulse when `Y` is updated.
- `SLOT` out `$clog2(SLOTS)`: index the next accepted sample will occupy.
- `ERR` out 1: alignment error indication.

## Operation
- Internal state: FSM {HUNT, LOCKED}; slot counter; shadow registers `SLOTS-1` x `WIDTH` (slots 0..SLOTS-2).
- Reset (`RST_N`=0, asynchronous):
  - FSM = HUNT.
  - Slot counter = 0.
  - Shadow = 0, `Y` = 0, `VALID` = 0, `ERR` = 0.
- HUNT:
  - `EN`=1, `SYNC`=0: sample discarded; no flag.
  - `EN`=1, `SYNC`=1: shadow[0] <= `D`; slot <= 1; FSM <= LOCKED.
- LOCKED, `EN`=1, slot s:
  - s=0, `SYNC`=1: shadow[0] <= `D`; slot <= 1.
  - s=0, `SYNC`=0: error; sample discarded; FSM <= HUNT; slot <= 0.
  - 0<s<SLOTS-1, `SYNC`=0: shadow[s] <= `D`; slot <= s+1.
  - s=SLOTS-1, `SYNC`=0: `Y` <= {`D`, shadow[SLOTS-2..0]}; `VALID` pulses; slot wraps to 0.
  - s≠0, `SYNC`=1 (early sync): error; partial frame abandoned (`Y` untouched); shadow[0] <= `D`; slot <= 1; stays LOCKED.
- `EN`=0: no state change; `SYNC`/`D` ignored; `SLOT` holds.
- `Y` holds its value until the next complete frame. Partial frames never reach `Y`.
- `SLOTS`=2 degenerates correctly: sync sample, then last sample.

## Timing
- All outputs are registered. Changes appear after the rising `CLK` edge that samples the causing input.
- Frame latency: `Y`/`VALID` update on the same edge that accepts slot SLOTS-1. Earliest frame is `SLOTS` enabled edges after SYNC is first seen (4 edges at default).
- `VALID` is high exactly one cycle per frame, then low, even if `EN` stays high.
- `ERR` (default build) is high exactly one cycle per error event.
- Back-to-back frames at `EN`=1 every cycle are sustained. `VALID` then pulses every `SLOTS` cycles.
- `RST_N` asserted mid-frame: all outputs go to reset values immediately, without waiting for a clock. After release, SYNC is required before any data is accepted.
- `RST_N` release is taken synchronously on the next `CLK` edge; the first edge with `RST_N`=1 is a normal operating edge.

## Configuration
- `ACT7_TDM_STICKY_ERR_EN`:
  - Defined: `ERR` is sticky. It is set by the first error and stays high until `RST_N` is asserted; frame recovery behaviour is otherwise unchanged.
  - Undefined: `ERR` is a one-cycle pulse per error event.

## Test plan
All scenarios use `WIDTH`=8, `SLOTS`=4.
- Reset: hold `RST_N`=0 with random `D`/`EN` -> `Y`=32'h0, `VALID`=0, `ERR`=0, `SLOT`=0.
- Normal frame: `EN`=1 each cycle; `D`=A0 (`SYNC`=1), A1, A2, A3 -> after 4th edge `Y`=32'hA3A2A1A0, `VALID`=1 for one cycle. Repeat with B0..B3 -> `Y`=32'hB3B2B1B0 exactly 4 cycles later.
- Gapped `EN`: same samples with 2 `EN`=0 cycles between each -> `SLOT` holds 1/2/3 across gaps; same `Y`; single `VALID`.
- Early sync: C0 (`SYNC`), C1, then `SYNC`=1 with D0, then D1, D2, D3 -> `ERR` pulses on the D0 edge; no `VALID` for the C frame; then `Y`=32'hD3D2D1D0.
- Missing sync plus pre-sync data:
  - Frame E0..E3 completes.
  - Next slot-0 sample 55 arrives with `SYNC`=0 -> `ERR` pulse, HUNT entered.
  - Samples 66, 77 with `SYNC`=0 are ignored; `Y` stays 32'hE3E2E1E0.
  - Check again with `ACT7_TDM_STICKY_ERR_EN` defined -> `ERR` stays 1 until reset.
- Reset mid-frame: F0 (`SYNC`), F1, then pulse `RST_N` low between clock edges -> outputs cleared immediately. After release, samples without `SYNC` produce no `VALID`; a fresh synced frame is received normally.
